depth_test_unit: RTL
====================

// Module: depth_test_unit
// PURPOSE
//   Parametrised successor of the per-pixel depth test. Owns the 1/z buffer (BRAM), does
//   frustum reject and a run-time-selectable compare. Sits between rasteriser and
//   frame-buffer writer. Adds valid/ready input handshake, read-after-write forwarding and
//   a self-sequenced full-buffer clear FSM.
// PARAMETERS
//   BUFFER_WIDTH       160                 pixels per row
//   BUFFER_HEIGHT      120                 rows
//   BUFFER_ADDR_WIDTH  $clog2(W*H)         pixel address width
//   DEPTH_BITS         TOTAL_WIDTH/2       stored depth width; incoming depth truncated to low DEPTH_BITS
//   CLEAR_VALUE        '0                  value written by clear sweep (1/z = 0 is "infinitely far")
//   NEAR_PLANE         1.0                 real; REC_NEAR = rtof(1/NEAR_PLANE)
//   FAR_PLANE          10.0                real; REC_FAR  = rtof(1/FAR_PLANE)
// PORTS
//   clk            in   1                  clock
//   rst            in   1                  synchronous, active-high reset
//   in_valid       in   1                  pixel request valid
//   in_ready       out  1                  unit can accept (low while clearing)
//   in_pixel       in   pixel_data_t       pixel incl. depth (fixed, 1/z)
//   in_addr        in   BUFFER_ADDR_WIDTH  linear pixel address
//   cmp_mode       in   depth_cmp_t        GREATER / GEQUAL / ALWAYS / NEVER; sampled with the pixel
//   clear_start    in   1                  pulse: begin full-buffer clear
//   clear_busy     out  1                  clear sweep in progress
//   out_valid      out  1                  pixel passed test; write to frame buffer
//   out_addr       out  BUFFER_ADDR_WIDTH  address of passing pixel
//   out_pixel      out  pixel_data_t       passing pixel
// BEHAVIOUR
//   - Reset: in_ready=0 in reset cycle, then 1; out_valid=0, clear_busy=0, FSM=IDLE,
//     pipeline valids cleared. BRAM contents not reset (clear_start required after power-up).
//   - Accept when in_valid && in_ready. No output backpressure; downstream always accepts.
//   - Pipeline: S1 latch + BRAM read issue; S2 read data valid, compare, BRAM write and
//     registered out_*. out_valid asserted 2 cycles after accept; throughput 1 pixel/cycle.
//   - Test in S2 (d = truncated pixel depth, z = stored/forwarded):
//     * reject if pixel.depth < REC_FAR or > REC_NEAR (all modes, incl. ALWAYS);
//     * GREATER: d > z; GEQUAL: d >= z; ALWAYS: pass; NEVER: fail.
//     * Pass -> BRAM[addr] <= d same cycle, out_valid=1 next edge.
//   - Forwarding: if S2 writes addr A while S1 reads A, S2 uses the written d, not BRAM
//     data. Any run of same-address pixels gives identical results to one-per-3-cycles issue.
//   - Clear FSM: IDLE -> DRAIN (clear_start; in_ready=0, 2 cycles for in-flight pixels)
//     -> SWEEP (one addr/cycle, 0..W*H-1, write CLEAR_VALUE) -> IDLE after last addr.
//     clear_busy=1 in DRAIN/SWEEP. clear_start while busy ignored (no restart).
//     Sweep takes W*H cycles; in_ready=1 on the cycle after the last address write.
//   - rst mid-sweep: FSM to IDLE, partial clear left; no pending restart.
//   - Address >= W*H: request accepted, treated as reject, no BRAM access.
// CONFIGURATION
//   DEPTH_TEST_STATS_EN defined: adds outputs stat_pass, stat_reject_frustum,
//     stat_reject_depth (32 b each, saturating), zeroed on rst and on clear_start accept.
//   Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//   types_pkg: depth_cmp_t enum, pixel_data_t (existing). fixed_pkg: fixed, rtof, TOTAL_WIDTH.
//   Sub-module depth_ram: simple dual-port BRAM (1 read, 1 write, registered read,
//   read-first); clear and test writes share its write port via an FSM mux.
// TESTING
//   1 rst, clear_start, wait clear_busy=0 -> exactly W*H=19200 sweep cycles; read-back all 0.
//   2 GREATER, addr 5: depth 0.5 then 0.3 -> first out_valid=1, second 0; BRAM[5]=0.5.
//   3 Back-to-back addr 7: 0.2, 0.4, 0.3 -> pass, pass, reject (forwarding).
//   4 depth 0.05 and 1.5 in ALWAYS -> both rejected; depth 0.1 (=REC_FAR) in GEQUAL vs 0 -> pass.
//   5 clear_start with 2 pixels in flight -> both resolve, in_ready=0 until sweep done.
//   6 rst at sweep addr 100 -> clear_busy=0 next cycle, in_ready=1 after.

Source files
------------

// File: rtl/depth_test_unit_pkg.sv
// Shared types for the depth test unit: fixed-point 1/z format, pixel record, compare modes.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package depth_test_unit_pkg;

  localparam int TOTAL_WIDTH = 32;
  // One integer bit above the fraction, so every in-frustum 1/z (at most 1.0)
  // survives truncation to TOTAL_WIDTH/2 stored bits.
  localparam int FRAC_BITS   = TOTAL_WIDTH / 2 - 1;

  // Cycles the clear sequencer waits for in-flight pixels before sweeping.
  localparam int DRAIN_CYCLES = 2;

  typedef logic [TOTAL_WIDTH-1:0] fixed;

  typedef enum logic [1:0] {
    CMP_GREATER = 2'd0,
    CMP_GEQUAL  = 2'd1,
    CMP_ALWAYS  = 2'd2,
    CMP_NEVER   = 2'd3
  } depth_cmp_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    fixed       depth;
  } pixel_data_t;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_DRAIN = 2'd1,
    CLR_SWEEP = 2'd2
  } clear_state_t;

  // Elaboration-time real -> fixed conversion (truncates toward zero).
  function automatic fixed rtof(input real r);
    return fixed'($rtoi(r * (2.0 ** FRAC_BITS)));
  endfunction

endpackage

// File: rtl/depth_test_unit_ram.sv
// Simple dual-port depth store: one registered read port, one write port, read-first.
// Latency: read data valid one cycle after rd_en; write lands on the clock edge.
// Backpressure: none; both ports accept every cycle.
module depth_test_unit_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_dat,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Registered read; a same-edge write is not visible (read-first).
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/depth_test_unit.sv
// Per-pixel 1/z depth test with frustum reject, selectable compare and self-sequenced buffer clear.
// Latency: out_valid two cycles after accept, one pixel per cycle; clear = 2 drain + W*H sweep cycles.
// Backpressure: in_ready low during clear only; output has none. Optional DEPTH_TEST_STATS_EN adds counters.
module depth_test_unit
  import depth_test_unit_pkg::*;
#(
  parameter int                 BUFFER_WIDTH      = 160,
  parameter int                 BUFFER_HEIGHT     = 120,
  parameter int                 BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int                 DEPTH_BITS        = TOTAL_WIDTH / 2,
  parameter logic [DEPTH_BITS-1:0] CLEAR_VALUE    = '0,
  parameter real                NEAR_PLANE        = 1.0,
  parameter real                FAR_PLANE         = 10.0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  pixel_data_t                  in_pixel,
  input  logic [BUFFER_ADDR_WIDTH-1:0] in_addr,
  input  depth_cmp_t                   cmp_mode,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         out_valid,
  output logic [BUFFER_ADDR_WIDTH-1:0] out_addr,
  output pixel_data_t                  out_pixel
`ifdef DEPTH_TEST_STATS_EN
  ,
  output logic [31:0]                  stat_pass,
  output logic [31:0]                  stat_reject_frustum,
  output logic [31:0]                  stat_reject_depth
`endif
);

  localparam int NUM_PIXELS = BUFFER_WIDTH * BUFFER_HEIGHT;
  localparam logic [BUFFER_ADDR_WIDTH-1:0] LAST_ADDR = BUFFER_ADDR_WIDTH'(NUM_PIXELS - 1);
  localparam fixed REC_NEAR = rtof(1.0 / NEAR_PLANE);
  localparam fixed REC_FAR  = rtof(1.0 / FAR_PLANE);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  // Clear sequencer state.
  clear_state_t                 clr_state;
  logic [1:0]                   drain_cnt;
  logic [BUFFER_ADDR_WIDTH-1:0] sweep_addr;

  // Stage 1: latched request, BRAM read in flight.
  logic                         s1_vld;
  pixel_data_t                  s1_pixel;
  logic [BUFFER_ADDR_WIDTH-1:0] s1_addr;
  depth_cmp_t                   s1_mode;
  logic                         s1_addr_ok;

  // Stage 2: read data available, decision and write.
  logic                         s2_vld;
  pixel_data_t                  s2_pixel;
  logic [BUFFER_ADDR_WIDTH-1:0] s2_addr;
  depth_cmp_t                   s2_mode;
  logic                         s2_addr_ok;
  logic                         s2_fwd_vld;
  logic [DEPTH_BITS-1:0]        s2_fwd_dat;

  logic [DEPTH_BITS-1:0]        s2_d;
  logic [DEPTH_BITS-1:0]        s2_z;
  logic                         s2_in_frustum;
  logic                         s2_cmp_ok;
  logic                         s2_pass;

  // RAM ports.
  logic                         rd_en;
  logic [DEPTH_BITS-1:0]        rd_dat;
  logic                         wr_en;
  logic [BUFFER_ADDR_WIDTH-1:0] wr_addr;
  logic [DEPTH_BITS-1:0]        wr_dat;

  logic accept;
  logic clear_accept;

  assign accept       = in_valid && in_ready;
  assign clear_accept = clear_start && (clr_state == CLR_IDLE);

  // Clear sequencer: drain in-flight pixels, sweep every address, then reopen the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_state  <= CLR_IDLE;
      drain_cnt  <= '0;
      sweep_addr <= '0;
      clear_busy <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      case (clr_state)
        CLR_IDLE: begin
          in_ready   <= 1'b1;
          clear_busy <= 1'b0;
          if (clear_start) begin
            clr_state  <= CLR_DRAIN;
            drain_cnt  <= '0;
            in_ready   <= 1'b0;
            clear_busy <= 1'b1;
          end
        end
        CLR_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            clr_state  <= CLR_SWEEP;
            sweep_addr <= '0;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        CLR_SWEEP: begin
          if (sweep_addr == LAST_ADDR) begin
            clr_state  <= CLR_IDLE;
            in_ready   <= 1'b1;
            clear_busy <= 1'b0;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        default: begin
          clr_state  <= CLR_IDLE;
          clear_busy <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1 latch; out-of-range addresses are flagged here and never touch the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= accept;
    end
    if (accept) begin
      s1_pixel   <= in_pixel;
      s1_addr    <= in_addr;
      s1_mode    <= cmp_mode;
      s1_addr_ok <= (in_addr <= LAST_ADDR);
    end
  end

  assign rd_en = s1_vld && s1_addr_ok;

  // Stage 2 latch, plus forwarding of a write the read-first RAM missed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld     <= 1'b0;
      s2_fwd_vld <= 1'b0;
    end else begin
      s2_vld     <= s1_vld;
      s2_fwd_vld <= s1_vld && s2_pass && (s1_addr == s2_addr);
    end
    s2_fwd_dat <= s2_d;
    if (s1_vld) begin
      s2_pixel   <= s1_pixel;
      s2_addr    <= s1_addr;
      s2_mode    <= s1_mode;
      s2_addr_ok <= s1_addr_ok;
    end
  end

  assign s2_d          = s2_pixel.depth[DEPTH_BITS-1:0];
  assign s2_z          = s2_fwd_vld ? s2_fwd_dat : rd_dat;
  assign s2_in_frustum = (s2_pixel.depth >= REC_FAR) && (s2_pixel.depth <= REC_NEAR);

  // Depth compare selected by the mode sampled with the pixel.
  always_comb begin
    s2_cmp_ok = 1'b0;
    case (s2_mode)
      CMP_GREATER: s2_cmp_ok = (s2_d > s2_z);
      CMP_GEQUAL:  s2_cmp_ok = (s2_d >= s2_z);
      CMP_ALWAYS:  s2_cmp_ok = 1'b1;
      CMP_NEVER:   s2_cmp_ok = 1'b0;
      default:     s2_cmp_ok = 1'b0;
    endcase
  end

  assign s2_pass = s2_vld && s2_addr_ok && s2_in_frustum && s2_cmp_ok;

  // Write port mux: sweep owns it while clearing, otherwise passing pixels write.
  always_comb begin
    wr_en   = s2_pass;
    wr_addr = s2_addr;
    wr_dat  = s2_d;
    if (clr_state == CLR_SWEEP) begin
      wr_en   = 1'b1;
      wr_addr = sweep_addr;
      wr_dat  = CLEAR_VALUE;
    end
  end

  // Registered output of passing pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= s2_pass;
    end
    if (s2_pass) begin
      out_addr  <= s2_addr;
      out_pixel <= s2_pixel;
    end
  end

  depth_test_unit_ram #(
    .DEPTH  (NUM_PIXELS),
    .ADDR_W (BUFFER_ADDR_WIDTH),
    .DATA_W (DEPTH_BITS)
  ) u_ram (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_addr (s1_addr),
    .rd_dat  (rd_dat),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_dat  (wr_dat)
  );

`ifdef DEPTH_TEST_STATS_EN
  // Saturating outcome counters for in-range pixels, restarted by reset or an accepted clear.
  always_ff @(posedge clk) begin
    if (rst || clear_accept) begin
      stat_pass           <= '0;
      stat_reject_frustum <= '0;
      stat_reject_depth   <= '0;
    end else if (s2_vld && s2_addr_ok) begin
      if (!s2_in_frustum) begin
        if (stat_reject_frustum != '1) stat_reject_frustum <= stat_reject_frustum + 32'd1;
      end else if (s2_cmp_ok) begin
        if (stat_pass != '1) stat_pass <= stat_pass + 32'd1;
      end else begin
        if (stat_reject_depth != '1) stat_reject_depth <= stat_reject_depth + 32'd1;
      end
    end
  end
`else
  logic unused_clear_accept;
  assign unused_clear_accept = clear_accept;
`endif

endmodule
